seg7_sequence_decoder: RTL and testbench

Receive-side monitor for the 7-segment drive produced by the mod-6 counter display path.
- Samples the seven active-low segment lines and filters out transient patterns.
- Decodes each stable pattern back to a binary digit and checks that the digits follow the mod-MODULUS count order.
- Used as a self-check block beside the counter display and as a scoreboard source in the processor bring-up bench.

---
 rtl/seg7_pkg.sv | 37 +++
 rtl/seg7_pattern_decode.sv | 45 ++++
 rtl/seg7_sequence_decoder.sv | 136 +++++++++++++
 tb/tb_seg7_sequence_decoder.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and types for the 7-segment sequence monitor
//
// Purpose : segment pattern constants, FSM state type and decode-result kind.
// Pattern bit order is {G,F,E,D,C,B,A}. Segments are active-low, so 0 means lit.
// The hex constants (A..F) are used only when SEG7_DECODE_HEX_EN is defined.
package seg7_pkg;

  localparam logic [6:0] SEG7_0     = 7'b1000000;
  localparam logic [6:0] SEG7_1     = 7'b1111001;
  localparam logic [6:0] SEG7_2     = 7'b0100100;
  localparam logic [6:0] SEG7_3     = 7'b0110000;
  localparam logic [6:0] SEG7_4     = 7'b0011001;
  localparam logic [6:0] SEG7_5     = 7'b0010010;
  localparam logic [6:0] SEG7_6     = 7'b0000010;
  localparam logic [6:0] SEG7_7     = 7'b1111000;
  localparam logic [6:0] SEG7_8     = 7'b0000000;
  localparam logic [6:0] SEG7_9     = 7'b0010000;
  localparam logic [6:0] SEG7_A     = 7'b0001000;
  localparam logic [6:0] SEG7_B     = 7'b0000011;
  localparam logic [6:0] SEG7_C     = 7'b1000110;
  localparam logic [6:0] SEG7_D     = 7'b0100001;
  localparam logic [6:0] SEG7_E     = 7'b0000110;
  localparam logic [6:0] SEG7_F     = 7'b0001110;
  localparam logic [6:0] SEG7_BLANK = 7'b1111111;

  typedef enum logic {
    S_UNLOCK,
    S_LOCKED
  } seg7_state_e;

  typedef enum logic [1:0] {
    DIGIT,
    BLANK,
    INVALID
  } seg7_kind_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// rtl/seg7_pattern_decode.sv - combinational 7-segment pattern to digit lookup
//
// Purpose : maps a 7-bit active-low pattern {G,F,E,D,C,B,A} to a 4-bit value
//           and a result kind (DIGIT, BLANK or INVALID).
// Macro   : SEG7_DECODE_HEX_EN - when defined, the A..F glyphs decode to 10..15.
//           When it is not defined, those glyphs decode as INVALID.
// Ports   : pat   in  7  sampled segment pattern
//           value out 4  decoded digit, 0 when the pattern is not a digit
//           kind  out 2  result kind
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pat,
  output logic [3:0] value,
  output seg7_kind_e kind
);

  always_comb begin
    value = 4'd0;
    kind  = DIGIT;
    case (pat)
      SEG7_0:     value = 4'd0;
      SEG7_1:     value = 4'd1;
      SEG7_2:     value = 4'd2;
      SEG7_3:     value = 4'd3;
      SEG7_4:     value = 4'd4;
      SEG7_5:     value = 4'd5;
      SEG7_6:     value = 4'd6;
      SEG7_7:     value = 4'd7;
      SEG7_8:     value = 4'd8;
      SEG7_9:     value = 4'd9;
`ifdef SEG7_DECODE_HEX_EN
      SEG7_A:     value = 4'd10;
      SEG7_B:     value = 4'd11;
      SEG7_C:     value = 4'd12;
      SEG7_D:     value = 4'd13;
      SEG7_E:     value = 4'd14;
      SEG7_F:     value = 4'd15;
`endif
      SEG7_BLANK: kind  = BLANK;
      default:    kind  = INVALID;
    endcase
  end

endmodule

// File: rtl/seg7_sequence_decoder.sv
// rtl/seg7_sequence_decoder.sv - filters, decodes and order-checks a 7-segment digit stream
//
// Purpose : samples the seven active-low segment lines and removes short glitches.
//           Each stable pattern is decoded back to a digit. The block checks that
//           successive digits follow the mod-MODULUS count order.
// Macro   : SEG7_DECODE_HEX_EN - enables decoding of the A..F glyphs as digits 10..15.
// Ports   : clk              in   1      rising-edge clock
//           clrn             in   1      synchronous active-low reset
//           segmentA..G      in   1 each active-low segment lines
//           digit            out  4      last accepted digit
//           digit_valid      out  1      pulse when a digit is accepted
//           blank            out  1      accepted pattern is all-off
//           pattern_invalid  out  1      pulse when an undecodable pattern is accepted
//           seq_error        out  1      sticky ordering violation
//           locked           out  1      synchronised to a digit sequence
//           step_count       out  CNT_W  number of correctly ordered steps (wraps)
module seg7_sequence_decoder
  import seg7_pkg::*;
#(
  parameter int MODULUS       = 6,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             segmentA,
  input  logic             segmentB,
  input  logic             segmentC,
  input  logic             segmentD,
  input  logic             segmentE,
  input  logic             segmentF,
  input  logic             segmentG,
  output logic [3:0]       digit,
  output logic             digit_valid,
  output logic             blank,
  output logic             pattern_invalid,
  output logic             seq_error,
  output logic             locked,
  output logic [CNT_W-1:0] step_count
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam logic [SW-1:0] STAB_MAX    = SW'(STABLE_CYCLES);
  localparam logic [SW-1:0] STAB_ACCEPT = SW'(STABLE_CYCLES - 1);

  logic [6:0]    seg_q;
  logic [6:0]    candidate;
  logic [6:0]    accepted_pat;
  logic [SW-1:0] stab_cnt;
  seg7_state_e   state;

  logic [3:0]    dec_value;
  seg7_kind_e    dec_kind;
  logic          accept;
  logic [3:0]    succ;

  // Decode the candidate. When accept is high it equals seg_q.
  seg7_pattern_decode u_decode (
    .pat   (candidate),
    .value (dec_value),
    .kind  (dec_kind)
  );

  // Candidate has been seen STABLE_CYCLES times in a row, counting this sample.
  // It must also differ from the pattern already accepted.
  assign accept = (seg_q == candidate) && (stab_cnt == STAB_ACCEPT) &&
                  (candidate != accepted_pat);

  // True modulo, so an out-of-range current digit still has a defined successor.
  assign succ = 4'((int'(digit) + 1) % MODULUS);

  always_ff @(posedge clk) begin
    seg_q <= {segmentG, segmentF, segmentE, segmentD, segmentC, segmentB, segmentA};
    if (!clrn) begin
      candidate       <= SEG7_BLANK;
      accepted_pat    <= SEG7_BLANK;
      stab_cnt        <= '0;
      state           <= S_UNLOCK;
      digit           <= 4'd0;
      digit_valid     <= 1'b0;
      blank           <= 1'b0;
      pattern_invalid <= 1'b0;
      seq_error       <= 1'b0;
      locked          <= 1'b0;
      step_count      <= '0;
    end else begin
      digit_valid     <= 1'b0;
      pattern_invalid <= 1'b0;

      if (seg_q != candidate) begin
        candidate <= seg_q;
        stab_cnt  <= SW'(1);
      end else if (stab_cnt != STAB_MAX) begin
        stab_cnt <= stab_cnt + SW'(1);
      end

      if (accept) begin
        accepted_pat <= candidate;
        case (dec_kind)
          DIGIT: begin
            digit       <= dec_value;
            digit_valid <= 1'b1;
            blank       <= 1'b0;
            case (state)
              S_UNLOCK: begin
                state  <= S_LOCKED;
                locked <= 1'b1;
              end
              default: begin
                // blank still high means the previous accept was a blank.
                // Showing the same digit again after a blank is a hold, not a step.
                if ((dec_value == digit) && blank) begin
                  step_count <= step_count;
                end else if (dec_value == succ) begin
                  step_count <= step_count + CNT_W'(1);
                end else begin
                  seq_error <= 1'b1;
                end
              end
            endcase
          end
          BLANK: begin
            blank <= 1'b1;
          end
          default: begin
            pattern_invalid <= 1'b1;
            blank           <= 1'b0;
            state           <= S_UNLOCK;
            locked          <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg7_sequence_decoder.sv
// tb/tb_seg7_sequence_decoder.sv - scoreboard bench for seg7_sequence_decoder
module tb_seg7_sequence_decoder;

  localparam int MODULUS       = 6;
  localparam int STABLE_CYCLES = 4;
  localparam int CNT_W         = 8;

  localparam logic [6:0] P0 = 7'b1000000;
  localparam logic [6:0] P1 = 7'b1111001;
  localparam logic [6:0] P2 = 7'b0100100;
  localparam logic [6:0] P3 = 7'b0110000;
  localparam logic [6:0] P4 = 7'b0011001;
  localparam logic [6:0] P5 = 7'b0010010;
  localparam logic [6:0] P7 = 7'b1111000;
  localparam logic [6:0] P8 = 7'b0000000;
  localparam logic [6:0] PA = 7'b0001000;
  localparam logic [6:0] PB = 7'b1111111;
  localparam logic [6:0] PX = 7'b1110000;

  logic             clk;
  logic             clrn;
  logic [6:0]       drv;
  logic [3:0]       digit;
  logic             digit_valid;
  logic             blank;
  logic             pattern_invalid;
  logic             seq_error;
  logic             locked;
  logic [CNT_W-1:0] step_count;

  seg7_sequence_decoder #(
    .MODULUS       (MODULUS),
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_W         (CNT_W)
  ) dut (
    .clk             (clk),
    .clrn            (clrn),
    .segmentA        (drv[0]),
    .segmentB        (drv[1]),
    .segmentC        (drv[2]),
    .segmentD        (drv[3]),
    .segmentE        (drv[4]),
    .segmentF        (drv[5]),
    .segmentG        (drv[6]),
    .digit           (digit),
    .digit_valid     (digit_valid),
    .blank           (blank),
    .pattern_invalid (pattern_invalid),
    .seq_error       (seq_error),
    .locked          (locked),
    .step_count      (step_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // kind: 0 digit, 1 blank, 2 invalid
  typedef struct {
    int         cyc;
    int         kind;
    logic [3:0] d;
    logic       blank;
    logic       err;
    logic       locked;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  logic [6:0] m_acc;
  logic [3:0] m_digit;
  logic       m_blank;
  logic       m_err;
  logic       m_locked;
  logic [7:0] m_cnt;

  function automatic logic [5:0] tb_decode(input logic [6:0] p);
    case (p)
      7'b1000000: return {2'd0, 4'd0};
      7'b1111001: return {2'd0, 4'd1};
      7'b0100100: return {2'd0, 4'd2};
      7'b0110000: return {2'd0, 4'd3};
      7'b0011001: return {2'd0, 4'd4};
      7'b0010010: return {2'd0, 4'd5};
      7'b0000010: return {2'd0, 4'd6};
      7'b1111000: return {2'd0, 4'd7};
      7'b0000000: return {2'd0, 4'd8};
      7'b0010000: return {2'd0, 4'd9};
`ifdef SEG7_DECODE_HEX_EN
      7'b0001000: return {2'd0, 4'd10};
      7'b0000011: return {2'd0, 4'd11};
      7'b1000110: return {2'd0, 4'd12};
      7'b0100001: return {2'd0, 4'd13};
      7'b0000110: return {2'd0, 4'd14};
      7'b0001110: return {2'd0, 4'd15};
`endif
      7'b1111111: return {2'd1, 4'd0};
      default:    return {2'd2, 4'd0};
    endcase
  endfunction

  task automatic model_reset();
    m_acc    = 7'b1111111;
    m_digit  = 4'd0;
    m_blank  = 1'b0;
    m_err    = 1'b0;
    m_locked = 1'b0;
    m_cnt    = 8'd0;
  endtask

  // Drive a pattern for hold cycles. If it will be accepted, push the expected event.
  task automatic present(input logic [6:0] p, input int hold);
    logic [5:0] r;
    int         k;
    logic [3:0] d;
    exp_t       e;
    drv = p;
    if (hold >= STABLE_CYCLES && p != m_acc) begin
      r = tb_decode(p);
      k = int'(r[5:4]);
      d = r[3:0];
      if (k == 0) begin
        if (!m_locked) m_locked = 1'b1;
        else if (d == m_digit && m_blank) m_cnt = m_cnt;
        else if (int'(d) == (int'(m_digit) + 1) % MODULUS) m_cnt = m_cnt + 8'd1;
        else m_err = 1'b1;
        m_digit = d;
        m_blank = 1'b0;
      end else if (k == 1) begin
        m_blank = 1'b1;
      end else begin
        m_blank  = 1'b0;
        m_locked = 1'b0;
      end
      m_acc    = p;
      e.cyc    = cyc + STABLE_CYCLES + 1;
      e.kind   = k;
      e.d      = m_digit;
      e.blank  = m_blank;
      e.err    = m_err;
      e.locked = m_locked;
      e.cnt    = m_cnt;
      sb.push_back(e);
    end
    repeat (hold) @(negedge clk);
  endtask

  task automatic do_reset();
    clrn = 1'b0;
    drv  = 7'b1111111;
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    model_reset();
    check("sb_empty_at_reset", sb.size(), 0);
  endtask

  // Monitor: every accept-type event pops one expectation
  logic blank_prev = 1'b0;
  exp_t got_e;
  int   obs_kind;
  always @(negedge clk) begin
    if (clrn === 1'b1 && (digit_valid || pattern_invalid || (blank && !blank_prev))) begin
      obs_kind = digit_valid ? 0 : (pattern_invalid ? 2 : 1);
      if (sb.size() == 0) begin
        check("unexpected_event", 1, 0);
      end else begin
        got_e = sb.pop_front();
        check("ev_kind",       obs_kind,   got_e.kind);
        check("ev_cycle",      cyc,        got_e.cyc);
        check("ev_digit",      digit,      got_e.d);
        check("ev_blank",      blank,      got_e.blank);
        check("ev_seq_error",  seq_error,  got_e.err);
        check("ev_locked",     locked,     got_e.locked);
        check("ev_step_count", step_count, got_e.cnt);
      end
    end
    blank_prev = blank;
  end

  task automatic check_cleared(input string tag);
    check({tag, "_digit"},           digit,           0);
    check({tag, "_digit_valid"},     digit_valid,     0);
    check({tag, "_blank"},           blank,           0);
    check({tag, "_pattern_invalid"}, pattern_invalid, 0);
    check({tag, "_seq_error"},       seq_error,       0);
    check({tag, "_locked"},          locked,          0);
    check({tag, "_step_count"},      step_count,      0);
  endtask

  initial begin
    model_reset();
    clrn = 1'b0;
    drv  = 7'b1111111;
    do_reset();
    check_cleared("reset");

    // First digit locks with no order check
    present(P0, 6);
    check("t1_locked", locked, 1);
    check("t1_count",  step_count, 0);

    // Short glitch is filtered, return to 0 is not re-accepted
    present(P1, 2);
    present(P0, 6);
    check("t3_digit", digit, 0);

    // Legal count order including the 5->0 wrap
    present(P1, 6); present(P2, 6); present(P3, 6); present(P4, 6);
    present(P5, 6); present(P0, 6); present(P1, 6);
    check("t2_count",     step_count, 7);
    check("t2_seq_error", seq_error,  0);

    // Order violation is sticky through later legal steps
    present(P2, 6);
    present(P4, 6);
    check("t4_digit",     digit,     4);
    check("t4_seq_error", seq_error, 1);
    present(P5, 6);
    present(P0, 6);
    check("t4_sticky", seq_error, 1);
    check("t4_count",  step_count, 10);

    // Invalid pattern unlocks; next digit relocks without error
    do_reset();
    present(P2, 6);
    present(PX, 6);
    check("t5_unlocked", locked, 0);
    present(P3, 6);
    check("t5_locked",    locked,    1);
    check("t5_seq_error", seq_error, 0);
    present(P7, 6);
    check("t5_ge_modulus_err", seq_error, 1);

    // Blank in between: same digit is a hold, the following step counts
    do_reset();
    present(P2, 6);
    present(PB, 6);
    check("t6_blank_high", blank, 1);
    present(P2, 6);
    check("t6_hold_count", step_count, 0);
    check("t6_hold_err",   seq_error,  0);
    present(P3, 6);
    check("t6_step_count", step_count, 1);
    present(P8, 6);
    check("t6_err_8", seq_error, 1);

    // Reset while a pattern is still being filtered
    present(P4, 2);
    clrn = 1'b0;
    @(negedge clk);
    check_cleared("midreset");
    drv = 7'b1111111;
    @(negedge clk);
    clrn = 1'b1;
    model_reset();
    sb.delete();

    // Hex glyph: invalid in the default build
    present(PA, 6);
    present(P5, 6);
    present(P0, 6);
    check("final_digit", digit, 0);
    repeat (3) @(negedge clk);

    check("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
